// File: rtl/note_detector.sv
// note_detector: counts set pixels of the binary filter output inside one
// rectangular window per note lane and reports a lane bitmap once per frame.
// Timing inputs are delayed to line up with the filter output before the
// pixel position is tracked.
module note_detector #(
  parameter int          LANES        = 5,
  parameter logic [10:0] LANE_X0      = 11'd400,
  parameter logic [10:0] LANE_WIDTH   = 11'd32,
  parameter logic [10:0] LANE_PITCH   = 11'd96,
  parameter logic [10:0] ROW_Y        = 11'd600,
  parameter logic [10:0] ROW_HEIGHT   = 11'd8,
  parameter logic [15:0] COUNT_THRESH = 16'd64,
  parameter int          PIPE_DELAY   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VSync,
  input  logic             VDE,
  input  logic             ProcessIn,
  input  logic             Enable,
  output logic [LANES-1:0] Notes,
  output logic             NotesValid
);

  // Detection band rows as 12-bit constants so the upper bound cannot wrap.
  localparam logic [11:0] ROW_LO = {1'b0, ROW_Y};
  localparam logic [11:0] ROW_HI = ROW_LO + {1'b0, ROW_HEIGHT} - 12'd1;

  logic             d_vsync;
  logic             d_vde;
  logic             vsync_p0;
  logic             vsync_p1;
  logic             vde_p0;
  logic             frame_evt;
  logic             line_end;
  logic [10:0]      x;
  logic [10:0]      y;
  logic             in_rows;
  logic             armed;
  logic [LANES-1:0] hit;
  logic [15:0]      acc      [LANES];
  logic [15:0]      acc_next [LANES];

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [11:0] lane_lo(input int i);
    return {1'b0, LANE_X0} + 12'(i) * {1'b0, LANE_PITCH};
  endfunction

  function automatic logic [11:0] lane_hi(input int i);
    return lane_lo(i) + {1'b0, LANE_WIDTH} - 12'd1;
  endfunction

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign d_vsync = VSync;
      assign d_vde   = VDE;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] vsync_dly;
      logic [PIPE_DELAY-1:0] vde_dly;

      // Delay the timing signals by the filter latency
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          vsync_dly <= '0;
          vde_dly   <= '0;
        end else begin
          vsync_dly[0] <= VSync;
          vde_dly[0]   <= VDE;
          for (int k = 1; k < PIPE_DELAY; k++) begin
            vsync_dly[k] <= vsync_dly[k-1];
            vde_dly[k]   <= vde_dly[k-1];
          end
        end
      end

      assign d_vsync = vsync_dly[PIPE_DELAY-1];
      assign d_vde   = vde_dly[PIPE_DELAY-1];
    end
  endgenerate

  // Edge-detection history of the delayed timing signals
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
      vde_p0   <= 1'b0;
    end else begin
      vsync_p0 <= d_vsync;
      vsync_p1 <= vsync_p0;
      vde_p0   <= d_vde;
    end
  end

  // A held-high sync gives a single event because only the rise is taken.
  assign frame_evt = vsync_p0 & ~vsync_p1;
  assign line_end  = ~d_vde & vde_p0;

  // Pixel position tracking: x per active pixel, y per line, frame clears both
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x <= '0;
      y <= '0;
    end else if (frame_evt) begin
      x <= '0;
      y <= '0;
    end else if (d_vde) begin
      x <= sat_inc11(x);
    end else if (line_end) begin
      x <= '0;
      y <= sat_inc11(y);
    end
  end

  assign in_rows = ({1'b0, y} >= ROW_LO) && ({1'b0, y} <= ROW_HI);

  // Per-lane window hit and next accumulator value
  always_comb begin
    hit = '0;
    for (int i = 0; i < LANES; i++) begin
      hit[i] = d_vde & ProcessIn & Enable & in_rows &
               ({1'b0, x} >= lane_lo(i)) & ({1'b0, x} <= lane_hi(i));
      acc_next[i] = hit[i] ? sat_inc16(acc[i]) : acc[i];
    end
  end

  // Accumulate hits, and at each frame event publish the lane decisions
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      armed      <= 1'b0;
      Notes      <= '0;
      NotesValid <= 1'b0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      NotesValid <= 1'b0;
      if (frame_evt) begin
        armed <= 1'b1;
        if (armed && Enable) begin
          NotesValid <= 1'b1;
          for (int i = 0; i < LANES; i++) Notes[i] <= (acc_next[i] >= COUNT_THRESH);
        end
      end
      for (int i = 0; i < LANES; i++) acc[i] <= (frame_evt || !Enable) ? 16'd0 : acc_next[i];
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed frames of 20 pixels x 6 lines driven into two
// note_detector instances (threshold 5 and threshold 1) with hand-computed
// lane bitmaps. Lane windows: lane 0 x=4..7, lane 1 x=12..15, rows y=2..3.
module tb_note_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       vde = 1'b0;
  logic       pin = 1'b0;
  logic       en = 1'b1;
  logic [1:0] notes0;
  logic [1:0] notes1;
  logic       nv0;
  logic       nv1;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         hist0 = 1'b0;
  bit         hist1 = 1'b0;
  int         fc;
  int         vs_start;
  int         strobes;
  int         strobe_at;
  logic [1:0] sn0;
  logic [1:0] sn1;
  logic [1:0] rst_notes;

  always #5 clk = ~clk;

  note_detector #(
    .LANES(2), .LANE_X0(11'd4), .LANE_WIDTH(11'd4), .LANE_PITCH(11'd8),
    .ROW_Y(11'd2), .ROW_HEIGHT(11'd2), .COUNT_THRESH(16'd5), .PIPE_DELAY(2)
  ) dut (
    .CLK(clk), .RST(rst), .VSync(vsync), .VDE(vde), .ProcessIn(pin),
    .Enable(en), .Notes(notes0), .NotesValid(nv0)
  );

  note_detector #(
    .LANES(2), .LANE_X0(11'd4), .LANE_WIDTH(11'd4), .LANE_PITCH(11'd8),
    .ROW_Y(11'd2), .ROW_HEIGHT(11'd2), .COUNT_THRESH(16'd1), .PIPE_DELAY(2)
  ) dut_t1 (
    .CLK(clk), .RST(rst), .VSync(vsync), .VDE(vde), .ProcessIn(pin),
    .Enable(en), .Notes(notes1), .NotesValid(nv1)
  );

  // Pixel patterns, indexed by mode, at active position (x, y).
  function automatic bit pix(input int mode, input int x, input int y);
    case (mode)
      0: return 1'b1;
      1: return (y == 2 && ((x >= 4 && x <= 7) || (x >= 12 && x <= 15))) || (y == 3 && x == 12);
      2: return (y == 1) || (y == 4) || ((y == 2 || y == 3) && ((x >= 8 && x <= 11) || x == 16));
      3: return (y == 2) && (x == 3 || x == 7);
      4: return (y == 2) && (x == 3);
      5: return (y == 2) && (x == 9 || x == 17);
      default: return 1'b0;
    endcase
  endfunction

  // One clock: ProcessIn follows the pixel stream two cycles late unless early.
  task automatic tick(input bit v, input bit vs, input bit p, input bit early);
    vde   = v;
    vsync = vs;
    pin   = early ? p : hist1;
    hist1 = hist0;
    hist0 = p;
    @(posedge clk);
    #1;
    fc++;
    if (nv0) begin
      strobes++;
      strobe_at = fc - vs_start - 1;
      sn0 = notes0;
    end
    if (nv1) sn1 = notes1;
  endtask

  task automatic run_frame(input int mode, input int en_line, input int rst_line, input int vs_len);
    bit early;
    early     = (mode == 5);
    strobes   = 0;
    strobe_at = -1;
    fc        = 0;
    vs_start  = 0;
    sn0       = 2'bxx;
    sn1       = 2'bxx;
    for (int line = 0; line < 6; line++) begin
      if (line == rst_line) begin
        rst = 1'b1;
        #1;
        rst_notes = notes0;
        tick(1'b0, 1'b0, 1'b0, early);
        rst = 1'b0;
      end
      en = (en_line < 6) && (line >= en_line);
      for (int x = 0; x < 20; x++) tick(1'b1, 1'b0, pix(mode, x, line), early);
      for (int b = 0; b < 4; b++) tick(1'b0, 1'b0, 1'b0, early);
    end
    vs_start = fc;
    for (int j = 0; j < vs_len; j++) tick(1'b0, 1'b1, 1'b0, early);
    for (int j = 0; j < 8; j++) tick(1'b0, 1'b0, 1'b0, early);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (notes0 !== 2'b00) begin n_bad++; $display("FAIL reset_notes: got %b want 00", notes0); end
    n_cmp++; if (nv0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", nv0); end
    n_cmp++; if (notes1 !== 2'b00) begin n_bad++; $display("FAIL reset_notes_t1: got %b want 00", notes1); end
    rst = 1'b0;
  endtask

  task automatic test_armed_discard;
    run_frame(0, 0, -1, 3);
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL discard_strobes: got %0d want 0", strobes); end
    n_cmp++; if (notes0 !== 2'b00) begin n_bad++; $display("FAIL discard_notes: got %b want 00", notes0); end
  endtask

  task automatic test_full_hits;
    run_frame(0, 0, -1, 3);
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL full_strobes: got %0d want 1", strobes); end
    n_cmp++; if (strobe_at !== 3) begin n_bad++; $display("FAIL full_latency: got %0d want 3", strobe_at); end
    n_cmp++; if (sn0 !== 2'b11) begin n_bad++; $display("FAIL full_notes: got %b want 11", sn0); end
    n_cmp++; if (sn1 !== 2'b11) begin n_bad++; $display("FAIL full_notes_t1: got %b want 11", sn1); end
  endtask

  task automatic test_threshold;
    run_frame(1, 0, -1, 3);
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL thresh_strobes: got %0d want 1", strobes); end
    n_cmp++; if (sn0 !== 2'b10) begin n_bad++; $display("FAIL thresh_notes: got %b want 10", sn0); end
    n_cmp++; if (sn1 !== 2'b11) begin n_bad++; $display("FAIL thresh_notes_t1: got %b want 11", sn1); end
  endtask

  task automatic test_out_of_window;
    run_frame(2, 0, -1, 3);
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL oow_strobes: got %0d want 1", strobes); end
    n_cmp++; if (sn0 !== 2'b00) begin n_bad++; $display("FAIL oow_notes: got %b want 00", sn0); end
    n_cmp++; if (sn1 !== 2'b00) begin n_bad++; $display("FAIL oow_notes_t1: got %b want 00", sn1); end
  endtask

  task automatic test_delay_alignment;
    run_frame(3, 0, -1, 3);
    n_cmp++; if (sn1 !== 2'b01) begin n_bad++; $display("FAIL align_x3_x7: got %b want 01", sn1); end
    n_cmp++; if (sn0 !== 2'b00) begin n_bad++; $display("FAIL align_x3_x7_t5: got %b want 00", sn0); end
    run_frame(4, 0, -1, 3);
    n_cmp++; if (sn1 !== 2'b00) begin n_bad++; $display("FAIL align_x3_only: got %b want 00", sn1); end
    run_frame(5, 0, -1, 3);
    n_cmp++; if (sn1 !== 2'b11) begin n_bad++; $display("FAIL align_early: got %b want 11", sn1); end
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL align_early_strobes: got %0d want 1", strobes); end
  endtask

  task automatic test_enable;
    run_frame(0, 0, -1, 3);
    n_cmp++; if (sn0 !== 2'b11) begin n_bad++; $display("FAIL en_before: got %b want 11", sn0); end
    run_frame(2, 6, -1, 3);
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL en_off_strobes: got %0d want 0", strobes); end
    n_cmp++; if (notes0 !== 2'b11) begin n_bad++; $display("FAIL en_off_hold: got %b want 11", notes0); end
    run_frame(0, 3, -1, 3);
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL en_mid_strobes: got %0d want 1", strobes); end
    n_cmp++; if (sn0 !== 2'b00) begin n_bad++; $display("FAIL en_mid_notes: got %b want 00", sn0); end
    n_cmp++; if (sn1 !== 2'b11) begin n_bad++; $display("FAIL en_mid_notes_t1: got %b want 11", sn1); end
  endtask

  task automatic test_back_to_back;
    run_frame(1, 0, -1, 10);
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL held_vsync_strobes: got %0d want 1", strobes); end
    n_cmp++; if (sn0 !== 2'b10) begin n_bad++; $display("FAIL held_vsync_notes: got %b want 10", sn0); end
  endtask

  task automatic test_midframe_reset;
    run_frame(0, 0, -1, 3);
    n_cmp++; if (notes0 !== 2'b11) begin n_bad++; $display("FAIL rst_pre_notes: got %b want 11", notes0); end
    run_frame(0, 0, 3, 3);
    n_cmp++; if (rst_notes !== 2'b00) begin n_bad++; $display("FAIL rst_async_clear: got %b want 00", rst_notes); end
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL rst_next_strobes: got %0d want 0", strobes); end
    n_cmp++; if (notes0 !== 2'b00) begin n_bad++; $display("FAIL rst_next_notes: got %b want 00", notes0); end
    run_frame(0, 0, -1, 3);
    n_cmp++; if (strobes !== 1) begin n_bad++; $display("FAIL rst_follow_strobes: got %0d want 1", strobes); end
    n_cmp++; if (sn0 !== 2'b11) begin n_bad++; $display("FAIL rst_follow_notes: got %b want 11", sn0); end
  endtask

  initial begin
    test_reset();
    test_armed_discard();
    test_full_hits();
    test_threshold();
    test_out_of_window();
    test_delay_alignment();
    test_enable();
    test_back_to_back();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
